gnt_burst_ctrl: RTL and testbench
=================================

# gnt_burst_ctrl

Downstream consumer of the two-client arbiter (`fsm2`). It turns the arbiter's `gnt_0`/`gnt_1` into ownership of one shared write bus. While a client holds the grant, the block moves up to `MAX_BURST` beats from that client onto the bus through a registered output stage. At the end of each burst it returns a one-cycle `done` pulse, and the client uses that pulse to drop its `req`.

## Interface
- `DATA_W`, 8: width of client and bus data.
- `MAX_BURST`, 4: maximum beats per grant tenure, legal range 1..255.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `gnt_0`, `gnt_1` in 1: grants from the arbiter.
- `valid_0`, `valid_1` in 1: client beat valid.
- `data_0`, `data_1` in `DATA_W`: client beat data.
- `ready_0`, `ready_1` out 1: client beat accepted when `valid_x & ready_x`.
- `done_0`, `done_1` out 1: one-cycle end-of-burst pulse.
- `bus_valid` out 1: shared bus beat valid.
- `bus_data` out `DATA_W`: shared bus data.
- `bus_owner` out 1: client index of the current `bus_data`.
- `bus_ready` in 1: bus sink accepts when `bus_valid & bus_ready`.
- `grant_err` out 1: sticky protocol error. Present only with `GNT_BURST_CHECK_EN`.

## Operation
- State machine states: `IDLE`, `OWN0`, `OWN1`, `DRAIN`.
- `IDLE` transitions:
  - `gnt_0 & !gnt_1` → `OWN0`; `gnt_1 & !gnt_0` → `OWN1`.
  - Both grants high: stay in `IDLE`.
  - Entering an `OWNx` state clears `beat_cnt`.
- Output register load condition: `load = !bus_valid | bus_ready`.
- In `OWNx`: `ready_x = gnt_x & load & (beat_cnt < MAX_BURST)`.
  - The other client's `ready` is 0.
  - `ready_x` is combinational from state, grant, count and `bus_ready`.
- Accepted beat (`valid_x & ready_x`):
  - registers `data_x` into `bus_data`;
  - sets `bus_valid` and `bus_owner = x`;
  - increments `beat_cnt`.
- If `load` is true and no beat is accepted, `bus_valid` clears.
- `OWNx` → `DRAIN` when either:
  - `gnt_x` is low, or
  - `beat_cnt == MAX_BURST`, evaluated after the cycle's increment.
- `DRAIN` → `IDLE` when the output register is empty or is being emptied, i.e. `!bus_valid | bus_ready`.
  - `done_<owner>` pulses high in the cycle of that transition.
- Grant drop mid-burst: `ready_x` goes low in the same cycle. Beats already registered still drain to the bus.
- A zero-beat tenure (grant withdrawn before any beat) still produces a `done` pulse.
- `beat_cnt` is `$clog2(MAX_BURST+1)` bits wide and never wraps; it saturates at `MAX_BURST`.

## Timing
- Reset values: all outputs 0; state `IDLE`; `beat_cnt` 0; `bus_data` 0.
- Reset asserted mid-burst: state and registered beat are discarded immediately, no `done` is emitted, and the block restarts in `IDLE`.
- Latency: a beat accepted at edge N appears on `bus_valid`/`bus_data` after edge N.
- Throughput: one beat per cycle while `bus_ready` stays high.
- Grant acquisition: 1 cycle from the `gnt_x` rise to `ready_x` possibly high (the `IDLE` → `OWNx` edge).
- Release: `done_x` is asserted at the earliest 1 cycle after the last beat is accepted, and only once that beat has left or is leaving the output register.
- Back-to-back tenures: `done` cycle → `IDLE` → next `OWN` state. Minimum 2 cycles between one client's last beat and the next client's first beat.

## Configuration
- `GNT_BURST_CHECK_EN` defined:
  - `grant_err` is set, and held until reset, if either occurs:
    - `gnt_0 & gnt_1` in any state;
    - a grant rises for the non-owner while in `OWNx` or `DRAIN`.
  - The block's data behaviour is unchanged.
- Not defined: the `grant_err` port and its logic are absent. Simultaneous grants are silently held in `IDLE`.

## Structure
- Shared package `gnt_burst_pkg` holds:
  - the state enum (`IDLE`, `OWN0`, `OWN1`, `DRAIN`);
  - client index constants (0, 1);
  - the `beat_cnt` width function.
- One natural sub-module, `gnt_out_reg`: the single-entry output register with the valid/ready load rule. It is instantiated once.
- The state machine, counter and client muxing stay in the top module.

## Test plan
- Reset with `reset=0` for 2 cycles: every output 0, including with `gnt_0` and `valid_0` held high.
- Single full burst: `gnt_0=1`, `valid_0=1` with data A1..A4, `bus_ready=1`, `MAX_BURST=4`.
  - `bus_data` shows A1..A4 on 4 consecutive cycles with `bus_owner=0`.
  - `done_0` pulses once, one cycle after A4 is accepted.
- Backpressure: `bus_ready=0` for 3 cycles mid-burst.
  - `ready_0` stays low and `bus_data` holds its value.
  - No beat is lost or duplicated; the total is still 4 beats.
- Grant drop: `gnt_1` deasserted after 2 beats B1, B2.
  - `ready_1` drops in the same cycle.
  - B2 drains, then `done_1` pulses; no third beat is accepted.
- Alternation: `gnt_0` then `gnt_1`, 2 beats each. The bus order is A1, A2, B1, B2, and `bus_owner` switches only after `done_0`.
- With `GNT_BURST_CHECK_EN` defined: assert `gnt_0=gnt_1=1` for 1 cycle.
  - `grant_err` is 1 from the next cycle and stays 1 until reset.
  - The state remains `IDLE`.

Source files
------------

// File: rtl/gnt_burst_pkg.sv
// rtl/gnt_burst_pkg.sv - shared types and helpers for the grant-to-burst controller
package gnt_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic CLIENT_0 = 1'b0;
    localparam logic CLIENT_1 = 1'b1;

    // Wide enough to hold MAX_BURST itself, so the counter saturates without wrapping.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/gnt_out_reg.sv
// rtl/gnt_out_reg.sv - single-entry registered output stage for the shared bus
module gnt_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_ready,
    input  logic              beat_valid,
    input  logic [DATA_W-1:0] beat_data,
    input  logic              beat_owner,
    output logic              load,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_owner
);

    assign load = !bus_valid | bus_ready;

    // Data and owner are held when the stage empties so the bus never shows stale mixes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_valid <= 1'b0;
            bus_data  <= '0;
            bus_owner <= 1'b0;
        end else if (load) begin
            bus_valid <= beat_valid;
            if (beat_valid) begin
                bus_data  <= beat_data;
                bus_owner <= beat_owner;
            end
        end
    end

endmodule

// File: rtl/gnt_burst_ctrl.sv
// rtl/gnt_burst_ctrl.sv - turns arbiter grants into bounded bursts on one shared bus
// Optional sticky grant_err checker enabled by defining GNT_BURST_CHECK_EN.
module gnt_burst_ctrl
    import gnt_burst_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic              valid_0,
    input  logic              valid_1,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    output logic              ready_0,
    output logic              ready_1,
    output logic              done_0,
    output logic              done_1,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_owner,
`ifdef GNT_BURST_CHECK_EN
    output logic              grant_err,
`endif
    input  logic              bus_ready
);

    localparam int                CNT_W   = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BURST);

    state_t             state;
    logic               owner;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               load;
    logic               room;
    logic               accept;
    logic               cur_gnt;
    logic               sel_owner;
    logic [DATA_W-1:0]  sel_data;
    logic               drain_go;

    assign room      = beat_cnt < MAX_CNT;
    assign ready_0   = (state == OWN0) & gnt_0 & load & room;
    assign ready_1   = (state == OWN1) & gnt_1 & load & room;
    assign accept    = (valid_0 & ready_0) | (valid_1 & ready_1);
    assign sel_owner = (state == OWN1) ? CLIENT_1 : CLIENT_0;
    assign sel_data  = (state == OWN1) ? data_1 : data_0;
    assign cur_gnt   = (state == OWN1) ? gnt_1 : gnt_0;
    assign cnt_next  = beat_cnt + CNT_W'(accept);

    // done fires in the same cycle DRAIN hands back to IDLE.
    assign drain_go  = (state == DRAIN) & load;
    assign done_0    = drain_go & (owner == CLIENT_0);
    assign done_1    = drain_go & (owner == CLIENT_1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= CLIENT_0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_0 & !gnt_1) begin
                        state    <= OWN0;
                        owner    <= CLIENT_0;
                        beat_cnt <= '0;
                    end else if (gnt_1 & !gnt_0) begin
                        state    <= OWN1;
                        owner    <= CLIENT_1;
                        beat_cnt <= '0;
                    end
                end
                OWN0, OWN1: begin
                    beat_cnt <= cnt_next;
                    if (!cur_gnt || cnt_next == MAX_CNT)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (load)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    gnt_out_reg #(.DATA_W(DATA_W)) u_out_reg (
        .clock      (clock),
        .reset      (reset),
        .bus_ready  (bus_ready),
        .beat_valid (accept),
        .beat_data  (sel_data),
        .beat_owner (sel_owner),
        .load       (load),
        .bus_valid  (bus_valid),
        .bus_data   (bus_data),
        .bus_owner  (bus_owner)
    );

`ifdef GNT_BURST_CHECK_EN
    logic gnt_0_q;
    logic gnt_1_q;
    logic rise_0;
    logic rise_1;
    logic err_hit;

    assign rise_0  = gnt_0 & !gnt_0_q;
    assign rise_1  = gnt_1 & !gnt_1_q;
    assign err_hit = (gnt_0 & gnt_1)
                   | ((state == OWN0) & rise_1)
                   | ((state == OWN1) & rise_0)
                   | ((state == DRAIN) & ((owner == CLIENT_0) ? rise_1 : rise_0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_0_q   <= 1'b0;
            gnt_1_q   <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            gnt_0_q <= gnt_0;
            gnt_1_q <= gnt_1;
            if (err_hit)
                grant_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gnt_burst_ctrl.sv
// tb/tb_gnt_burst_ctrl.sv - directed self-checking bench for gnt_burst_ctrl
module tb_gnt_burst_ctrl;

    logic       clock;
    logic       reset;
    logic       gnt_0, gnt_1, valid_0, valid_1;
    logic [7:0] data_0, data_1;
    logic       ready_0, ready_1, done_0, done_1;
    logic       bus_valid, bus_owner, bus_ready;
    logic [7:0] bus_data;
`ifdef GNT_BURST_CHECK_EN
    logic       grant_err;
`endif

    int n_chk = 0;
    int n_bad = 0;

    gnt_burst_ctrl #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .valid_0   (valid_0),
        .valid_1   (valid_1),
        .data_0    (data_0),
        .data_1    (data_1),
        .ready_0   (ready_0),
        .ready_1   (ready_1),
        .done_0    (done_0),
        .done_1    (done_1),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_owner (bus_owner),
`ifdef GNT_BURST_CHECK_EN
        .grant_err (grant_err),
`endif
        .bus_ready (bus_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ctl = {ready_0, ready_1, done_0, done_1, bus_valid}
    task automatic cyc(input string tag, input logic g0, input logic g1, input logic v0,
                       input logic v1, input logic [7:0] d0, input logic [7:0] d1,
                       input logic br, input logic [4:0] ctl, input logic bo,
                       input logic [7:0] bd);
        gnt_0 = g0; gnt_1 = g1; valid_0 = v0; valid_1 = v1;
        data_0 = d0; data_1 = d1; bus_ready = br;
        @(negedge clock);
        check(tag, {18'd0, ready_0, ready_1, done_0, done_1, bus_valid, bus_owner, bus_data},
                   {18'd0, ctl, bo, bd});
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        gnt_0 = 1'b1; gnt_1 = 1'b0; valid_0 = 1'b1; valid_1 = 1'b0;
        data_0 = 8'h5A; data_1 = 8'h00; bus_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_outs", {18'd0, ready_0, ready_1, done_0, done_1, bus_valid, bus_owner, bus_data}, 32'd0);
`ifdef GNT_BURST_CHECK_EN
        check("reset_err", {31'd0, grant_err}, 32'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b1;

        // full 4-beat burst, client 0
        cyc("t1c0", 1,0,1,0, 8'hA1,8'h00, 1, 5'b00000, 0, 8'h00);
        cyc("t1c1", 1,0,1,0, 8'hA1,8'h00, 1, 5'b10000, 0, 8'h00);
        cyc("t1c2", 1,0,1,0, 8'hA2,8'h00, 1, 5'b10001, 0, 8'hA1);
        cyc("t1c3", 1,0,1,0, 8'hA3,8'h00, 1, 5'b10001, 0, 8'hA2);
        cyc("t1c4", 1,0,1,0, 8'hA4,8'h00, 1, 5'b10001, 0, 8'hA3);
        cyc("t1c5", 1,0,1,0, 8'hA5,8'h00, 1, 5'b00101, 0, 8'hA4);
        cyc("t1c6", 0,0,0,0, 8'h00,8'h00, 1, 5'b00000, 0, 8'hA4);

        // backpressure mid-burst
        cyc("t2c0", 1,0,1,0, 8'h11,8'h00, 1, 5'b00000, 0, 8'hA4);
        cyc("t2c1", 1,0,1,0, 8'h11,8'h00, 1, 5'b10000, 0, 8'hA4);
        cyc("t2c2", 1,0,1,0, 8'h12,8'h00, 1, 5'b10001, 0, 8'h11);
        cyc("t2c3", 1,0,1,0, 8'h13,8'h00, 0, 5'b00001, 0, 8'h12);
        cyc("t2c4", 1,0,1,0, 8'h13,8'h00, 0, 5'b00001, 0, 8'h12);
        cyc("t2c5", 1,0,1,0, 8'h13,8'h00, 0, 5'b00001, 0, 8'h12);
        cyc("t2c6", 1,0,1,0, 8'h13,8'h00, 1, 5'b10001, 0, 8'h12);
        cyc("t2c7", 1,0,1,0, 8'h14,8'h00, 1, 5'b10001, 0, 8'h13);
        cyc("t2c8", 1,0,1,0, 8'h15,8'h00, 0, 5'b00001, 0, 8'h14);
        cyc("t2c9", 1,0,1,0, 8'h15,8'h00, 1, 5'b00101, 0, 8'h14);
        cyc("t2c10", 0,0,0,0, 8'h00,8'h00, 1, 5'b00000, 0, 8'h14);

        // grant drop after two beats, client 1
        cyc("t3c0", 0,1,0,1, 8'h00,8'hB1, 1, 5'b00000, 0, 8'h14);
        cyc("t3c1", 0,1,0,1, 8'h00,8'hB1, 1, 5'b01000, 0, 8'h14);
        cyc("t3c2", 0,1,0,1, 8'h00,8'hB2, 1, 5'b01001, 1, 8'hB1);
        cyc("t3c3", 0,0,0,1, 8'h00,8'hB3, 0, 5'b00001, 1, 8'hB2);
        cyc("t3c4", 0,0,0,1, 8'h00,8'hB3, 0, 5'b00001, 1, 8'hB2);
        cyc("t3c5", 0,0,0,1, 8'h00,8'hB3, 1, 5'b00011, 1, 8'hB2);
        cyc("t3c6", 0,0,0,0, 8'h00,8'h00, 1, 5'b00000, 1, 8'hB2);

        // zero-beat tenure
        cyc("z0", 1,0,0,0, 8'h00,8'h00, 1, 5'b00000, 1, 8'hB2);
        cyc("z1", 0,0,0,0, 8'h00,8'h00, 1, 5'b00000, 1, 8'hB2);
        cyc("z2", 0,0,0,0, 8'h00,8'h00, 1, 5'b00100, 1, 8'hB2);
        cyc("z3", 0,0,0,0, 8'h00,8'h00, 1, 5'b00000, 1, 8'hB2);

        // alternation A1,A2 then B1,B2
        cyc("a0", 1,0,1,0, 8'hA1,8'h00, 1, 5'b00000, 1, 8'hB2);
        cyc("a1", 1,0,1,0, 8'hA1,8'h00, 1, 5'b10000, 1, 8'hB2);
        cyc("a2", 1,0,1,0, 8'hA2,8'h00, 1, 5'b10001, 0, 8'hA1);
        cyc("a3", 0,0,0,0, 8'h00,8'h00, 1, 5'b00001, 0, 8'hA2);
        cyc("a4", 0,0,0,0, 8'h00,8'h00, 1, 5'b00100, 0, 8'hA2);
        cyc("a5", 0,1,0,1, 8'h00,8'hB1, 1, 5'b00000, 0, 8'hA2);
        cyc("a6", 0,1,0,1, 8'h00,8'hB1, 1, 5'b01000, 0, 8'hA2);
        cyc("a7", 0,1,0,1, 8'h00,8'hB2, 1, 5'b01001, 1, 8'hB1);
        cyc("a8", 0,0,0,0, 8'h00,8'h00, 1, 5'b00001, 1, 8'hB2);
        cyc("a9", 0,0,0,0, 8'h00,8'h00, 1, 5'b00010, 1, 8'hB2);
        cyc("a10", 0,0,0,0, 8'h00,8'h00, 1, 5'b00000, 1, 8'hB2);

`ifdef GNT_BURST_CHECK_EN
        check("err_clean", {31'd0, grant_err}, 32'd0);
`endif
        // simultaneous grants hold IDLE
        cyc("d0", 1,1,1,1, 8'hC1,8'hD1, 1, 5'b00000, 1, 8'hB2);
        cyc("d1", 1,1,1,1, 8'hC1,8'hD1, 1, 5'b00000, 1, 8'hB2);
        cyc("d2", 1,0,1,0, 8'hC1,8'h00, 1, 5'b00000, 1, 8'hB2);
        cyc("d3", 0,0,0,0, 8'h00,8'h00, 1, 5'b00000, 1, 8'hB2);
        cyc("d4", 0,0,0,0, 8'h00,8'h00, 1, 5'b00100, 1, 8'hB2);
        cyc("d5", 0,0,0,0, 8'h00,8'h00, 1, 5'b00000, 1, 8'hB2);
`ifdef GNT_BURST_CHECK_EN
        check("err_sticky", {31'd0, grant_err}, 32'd1);
`endif

        // reset asserted mid-burst
        cyc("r0", 1,0,1,0, 8'hE1,8'h00, 1, 5'b00000, 1, 8'hB2);
        cyc("r1", 1,0,1,0, 8'hE1,8'h00, 1, 5'b10000, 1, 8'hB2);
        data_0 = 8'hE2;
        reset  = 1'b0;
        @(negedge clock);
        check("rst_mid", {18'd0, ready_0, ready_1, done_0, done_1, bus_valid, bus_owner, bus_data}, 32'd0);
`ifdef GNT_BURST_CHECK_EN
        check("rst_err", {31'd0, grant_err}, 32'd0);
`endif
        @(posedge clock);
        #1;
        gnt_0 = 1'b0; valid_0 = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        cyc("rst_after", 0,0,0,0, 8'h00,8'h00, 1, 5'b00000, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
